// File: rtl/life_gen_scheduler_pkg.sv
// Shared board geometry, scheduler states and the preset pattern for the
// 8x8 Game of Life board.
package life_pkg;

  localparam int BIT_WIDTH  = 3;
  localparam int BIT_HEIGHT = 3;
  localparam int ADDR_W     = BIT_WIDTH + BIT_HEIGHT;
  localparam int CELLS      = 1 << ADDR_W;
  localparam int CNT_W      = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COPY    = 2'd2,
    COMPUTE = 2'd3
  } state_e;

  // Glider in the top-left corner plus a blinker on the right-hand side.
  localparam logic [CELLS-1:0] PRESET = 64'h0000_7000_0007_0402;

  function automatic logic preset_bit(input logic [ADDR_W-1:0] addr);
    return PRESET[addr];
  endfunction

endpackage

// File: rtl/life_gen_scheduler_if.sv
// Control/status bundle between a host (frame timing, user buttons) and the
// generation scheduler, including the board-side strobes it drives.
interface life_gen_scheduler_if #(
  parameter int SPEED_W = 3,
  parameter int GEN_W   = 16
);
  import life_pkg::*;

  logic               frame_tick;
  logic               run;
  logic               step;
  logic               reload;
  logic [SPEED_W-1:0] speed;

  logic [ADDR_W-1:0]  cell_addr;
  logic [ADDR_W-1:0]  nbr_addr;
  logic               load_en;
  logic               copy_en;
  logic               wr_en;
  logic               disp_sel;
  logic               busy;
  logic               gen_done;
  logic               overrun;
  logic [GEN_W-1:0]   gen_count;

  modport master (
    output frame_tick, run, step, reload, speed,
    input  cell_addr, nbr_addr, load_en, copy_en, wr_en, disp_sel,
    input  busy, gen_done, overrun, gen_count
  );

  modport slave (
    input  frame_tick, run, step, reload, speed,
    output cell_addr, nbr_addr, load_en, copy_en, wr_en, disp_sel,
    output busy, gen_done, overrun, gen_count
  );

endinterface

// File: rtl/life_gen_scheduler_frame_divider.sv
// Frame divider: counts idle frame ticks and flags when a free-running
// generation is due (every speed+1 frames while run is high).
module life_frame_divider #(
  parameter int SPEED_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               run,
  input  logic               clr,
  input  logic               hold,
  input  logic [SPEED_W-1:0] speed,
  output logic               gen_due
);

  logic [SPEED_W-1:0] frame_cnt_q;
  logic [SPEED_W-1:0] frame_cnt_d;

  // >= rather than == so a lowered speed applies on the very next tick.
  assign gen_due = tick & ~clr & ~hold & run & (frame_cnt_q >= speed);

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (tick) begin
      if (clr) begin
        frame_cnt_d = '0;
      end else if (!hold && run) begin
        if (frame_cnt_q >= speed) frame_cnt_d = '0;
        else                      frame_cnt_d = frame_cnt_q + SPEED_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

endmodule

// File: rtl/life_gen_scheduler.sv
// Generation scheduler: on each frame tick chooses reload / generation / idle
// and sequences the board through LOAD, COPY and COMPUTE address sweeps.
module life_gen_scheduler
  import life_pkg::*;
#(
  parameter int SPEED_W = 3,
  parameter int GEN_W   = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  life_gen_scheduler_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELLS - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CELLS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q,       state_d;
  logic [CNT_W-1:0]   cnt_q,         cnt_d;
  logic               step_pend_q,   step_pend_d;
  logic               reload_pend_q, reload_pend_d;
  logic [GEN_W-1:0]   gen_count_q,   gen_count_d;
  logic [ADDR_W-1:0]  cell_addr_q,   cell_addr_d;
  logic [ADDR_W-1:0]  nbr_addr_q,    nbr_addr_d;
  logic               load_en_q,     load_en_d;
  logic               copy_en_q,     copy_en_d;
  logic               wr_en_q,       wr_en_d;
  logic               disp_sel_q,    disp_sel_d;
  logic               busy_q,        busy_d;
  logic               gen_done_q,    gen_done_d;
  logic               overrun_q,     overrun_d;

  logic               tick_idle;
  logic               gen_due;

  assign tick_idle = bus.frame_tick & (state_q == IDLE);

  life_frame_divider #(
    .SPEED_W (SPEED_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick_idle),
    .run     (bus.run),
    .clr     (reload_pend_q),
    .hold    (step_pend_q),
    .speed   (bus.speed),
    .gen_due (gen_due)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    step_pend_d   = step_pend_q | bus.step;
    reload_pend_d = reload_pend_q | bus.reload;
    gen_count_d   = gen_count_q;

    case (state_q)
      IDLE: begin
        if (tick_idle) begin
          if (reload_pend_q) begin
            state_d       = LOAD;
            cnt_d         = '0;
            reload_pend_d = bus.reload;
          end else if (step_pend_q) begin
            state_d     = COPY;
            cnt_d       = '0;
            step_pend_d = bus.step;
          end else if (gen_due) begin
            state_d = COPY;
            cnt_d   = '0;
          end
        end
      end
      LOAD: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          cnt_d       = '0;
          gen_count_d = '0;
        end
      end
      COPY: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = COMPUTE;
          cnt_d   = '0;
        end
      end
      COMPUTE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_END) begin
          state_d     = IDLE;
          cnt_d       = '0;
          gen_count_d = gen_count_q + GEN_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Board strobes are decoded from the next state so they leave a flop.
    cell_addr_d = '0;
    nbr_addr_d  = '0;
    load_en_d   = 1'b0;
    copy_en_d   = 1'b0;
    wr_en_d     = 1'b0;
    disp_sel_d  = 1'b0;
    busy_d      = (state_d != IDLE);
    gen_done_d  = (state_q == COMPUTE) && (cnt_q == CNT_END);
    overrun_d   = bus.frame_tick && (state_q != IDLE);

    case (state_d)
      LOAD: begin
        load_en_d   = 1'b1;
        cell_addr_d = cnt_d[ADDR_W-1:0];
      end
      COPY: begin
        copy_en_d   = 1'b1;
        cell_addr_d = cnt_d[ADDR_W-1:0];
      end
      COMPUTE: begin
        // Cycle 0 only primes the neighbour pipeline; the write address
        // trails the lookahead address by one cell.
        disp_sel_d = 1'b1;
        if (cnt_d != '0) begin
          wr_en_d     = 1'b1;
          cell_addr_d = cnt_d[ADDR_W-1:0] - ADDR_W'(1);
        end
        if (cnt_d <= CNT_LAST) nbr_addr_d = cnt_d[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      step_pend_q   <= 1'b0;
      reload_pend_q <= 1'b0;
      gen_count_q   <= '0;
      cell_addr_q   <= '0;
      nbr_addr_q    <= '0;
      load_en_q     <= 1'b0;
      copy_en_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      disp_sel_q    <= 1'b0;
      busy_q        <= 1'b0;
      gen_done_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      step_pend_q   <= step_pend_d;
      reload_pend_q <= reload_pend_d;
      gen_count_q   <= gen_count_d;
      cell_addr_q   <= cell_addr_d;
      nbr_addr_q    <= nbr_addr_d;
      load_en_q     <= load_en_d;
      copy_en_q     <= copy_en_d;
      wr_en_q       <= wr_en_d;
      disp_sel_q    <= disp_sel_d;
      busy_q        <= busy_d;
      gen_done_q    <= gen_done_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.cell_addr = cell_addr_q;
  assign bus.nbr_addr  = nbr_addr_q;
  assign bus.load_en   = load_en_q;
  assign bus.copy_en   = copy_en_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.disp_sel  = disp_sel_q;
  assign bus.busy      = busy_q;
  assign bus.gen_done  = gen_done_q;
  assign bus.overrun   = overrun_q;
  assign bus.gen_count = gen_count_q;

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Directed bench for life_gen_scheduler: scheduling, phase sweeps, pending
// requests, overrun and asynchronous reset.
module tb_life_gen_scheduler;
  import life_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  life_gen_scheduler_if #(.SPEED_W(3), .GEN_W(16)) bif ();

  life_gen_scheduler #(.SPEED_W(3), .GEN_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fire_tick();
    bif.frame_tick = 1'b1;
    cyc(1);
    bif.frame_tick = 1'b0;
  endtask

  task automatic pulse_step();
    bif.step = 1'b1;
    cyc(1);
    bif.step = 1'b0;
  endtask

  task automatic pulse_reload();
    bif.reload = 1'b1;
    cyc(1);
    bif.reload = 1'b0;
  endtask

  task automatic idle_wait(input int n, output int busy_cycles, output int gens);
    busy_cycles = 0;
    gens = 0;
    for (int i = 0; i < n; i++) begin
      if (bif.busy === 1'b1) busy_cycles++;
      if (bif.gen_done === 1'b1) gens++;
      cyc(1);
    end
  endtask

  // Follows a generation from the first COPY cycle; inject_at >= 0 drives a
  // frame_tick during that COMPUTE cycle.
  task automatic expect_gen(input string tag, input int exp_cnt, input int inject_at);
    int bad;
    int ovr_seen;
    int exp_cell;
    int exp_nbr;
    logic exp_ovr;
    bad = 0;
    ovr_seen = 0;
    for (int k = 0; k < CELLS; k++) begin
      if (bif.copy_en !== 1'b1 || bif.cell_addr !== ADDR_W'(k) || bif.disp_sel !== 1'b0 ||
          bif.wr_en !== 1'b0 || bif.busy !== 1'b1 || bif.load_en !== 1'b0 || bif.overrun !== 1'b0)
        bad++;
      cyc(1);
    end
    check({tag, "_copy_bad_cycles"}, bad, 0);
    bad = 0;
    for (int k = 0; k <= CELLS; k++) begin
      exp_cell = (k == 0) ? 0 : k - 1;
      exp_nbr  = (k <= CELLS - 1) ? k : 0;
      exp_ovr  = (inject_at >= 0) && (k == inject_at + 1);
      if (bif.disp_sel !== 1'b1 || bif.copy_en !== 1'b0 || bif.busy !== 1'b1 ||
          bif.wr_en !== (k != 0) || bif.cell_addr !== ADDR_W'(exp_cell) ||
          bif.nbr_addr !== ADDR_W'(exp_nbr) || bif.overrun !== exp_ovr || bif.gen_done !== 1'b0)
        bad++;
      if (k >= 1 && k <= CELLS - 1 && int'(bif.nbr_addr) != int'(bif.cell_addr) + 1) bad++;
      if (bif.overrun === 1'b1) ovr_seen++;
      if (k == inject_at) bif.frame_tick = 1'b1;
      cyc(1);
      bif.frame_tick = 1'b0;
    end
    check({tag, "_compute_bad_cycles"}, bad, 0);
    if (inject_at >= 0) check({tag, "_overrun_pulses"}, ovr_seen, 1);
    check({tag, "_gen_done"}, bif.gen_done, 1);
    check({tag, "_gen_count"}, bif.gen_count, exp_cnt);
    check({tag, "_busy_after"}, bif.busy, 0);
    check({tag, "_disp_after"}, bif.disp_sel, 0);
    cyc(1);
    check({tag, "_gen_done_width"}, bif.gen_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    int g;
    int bad;
    bif.frame_tick = 1'b0;
    bif.run        = 1'b0;
    bif.step       = 1'b0;
    bif.reload     = 1'b0;
    bif.speed      = 3'd0;

    // Reset values
    #2 rst_n = 1'b0;
    cyc(3);
    check("rst_busy",      bif.busy, 0);
    check("rst_load_en",   bif.load_en, 0);
    check("rst_copy_en",   bif.copy_en, 0);
    check("rst_wr_en",     bif.wr_en, 0);
    check("rst_disp_sel",  bif.disp_sel, 0);
    check("rst_gen_done",  bif.gen_done, 0);
    check("rst_overrun",   bif.overrun, 0);
    check("rst_gen_count", bif.gen_count, 0);
    check("rst_cell_addr", bif.cell_addr, 0);
    check("rst_nbr_addr",  bif.nbr_addr, 0);
    rst_n = 1'b1;
    cyc(2);

    // Free run, one generation per frame
    bif.run = 1'b1;
    bif.speed = 3'd0;
    for (int gi = 1; gi <= 3; gi++) begin
      idle_wait(870, b, g);
      check($sformatf("run0_idle_busy_%0d", gi), b, 0);
      fire_tick();
      expect_gen($sformatf("run0_gen%0d", gi), gi, -1);
    end

    // speed = 3: generations on ticks 4, 8, 12
    bif.speed = 3'd3;
    for (int ti = 1; ti <= 12; ti++) begin
      fire_tick();
      idle_wait(200, b, g);
      check($sformatf("speed3_tick%0d_gens", ti), g, (ti % 4 == 0) ? 1 : 0);
    end
    check("speed3_gen_count", bif.gen_count, 6);

    // Single step with run low
    bif.run = 1'b0;
    bif.speed = 3'd0;
    pulse_step();
    idle_wait(100, b, g);
    check("step_waits_for_tick", b, 0);
    fire_tick();
    expect_gen("step", 7, -1);
    for (int ti = 0; ti < 2; ti++) begin
      fire_tick();
      idle_wait(200, b, g);
      check($sformatf("step_no_repeat_%0d", ti), b, 0);
    end

    // Reload and step pending together: LOAD first, step on the next tick
    pulse_reload();
    cyc(3);
    pulse_step();
    cyc(3);
    fire_tick();
    bad = 0;
    for (int k = 0; k < CELLS; k++) begin
      if (bif.load_en !== 1'b1 || bif.cell_addr !== ADDR_W'(k) || bif.copy_en !== 1'b0 ||
          bif.wr_en !== 1'b0 || bif.disp_sel !== 1'b0 || bif.busy !== 1'b1)
        bad++;
      cyc(1);
    end
    check("load_bad_cycles", bad, 0);
    check("load_end_load_en", bif.load_en, 0);
    check("load_end_busy", bif.busy, 0);
    check("load_gen_count", bif.gen_count, 0);
    check("load_no_gen_done", bif.gen_done, 0);
    cyc(20);
    fire_tick();
    expect_gen("post_load_step", 1, -1);
    fire_tick();
    idle_wait(200, b, g);
    check("post_load_quiet", b, 0);

    // speed = 1 with a tick injected mid-COMPUTE: overrun, frame_cnt untouched
    bif.run = 1'b1;
    bif.speed = 3'd1;
    fire_tick();
    idle_wait(200, b, g);
    check("ovr_tickA_quiet", b, 0);
    fire_tick();
    expect_gen("ovr_gen", 2, 10);
    cyc(50);
    fire_tick();
    idle_wait(200, b, g);
    check("ovr_tickC_quiet", b, 0);
    fire_tick();
    expect_gen("ovr_tickD", 3, -1);

    // Asynchronous reset at COMPUTE cycle 30
    bif.speed = 3'd0;
    cyc(20);
    fire_tick();
    cyc(CELLS + 30);
    check("pre_rst_wr_en", bif.wr_en, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", bif.busy, 0);
    check("async_rst_wr_en", bif.wr_en, 0);
    check("async_rst_disp_sel", bif.disp_sel, 0);
    check("async_rst_gen_count", bif.gen_count, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    fire_tick();
    expect_gen("after_rst", 1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
